esc_quad_pwm: RTL and testbench
===============================

Name: esc_quad_pwm

Overview:
Consumer of the flight controller's four 11-bit motor speed words. Converts each speed into a fixed-rate servo-style PWM pulse for one ESC per motor: front, back, left and right. All four channels share one period counter. Speeds are trimmed per channel, double-buffered, and applied only at frame boundaries, so a pulse is never truncated or stretched mid-frame.

Parameters:
PERIOD, 125000, frame length in clk cycles (400 Hz at 50 MHz)
MIN_PULSE, 50000, pulse high time in cycles for compensated speed 0 (1.0 ms)
SCALE, 24, cycles of high time added per speed LSB

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frnt_spd  in  11  unsigned front motor speed
bck_spd  in  11  unsigned back motor speed
lft_spd  in  11  unsigned left motor speed
rght_spd  in  11  unsigned right motor speed
frnt_off  in  10  unsigned calibration trim, front
bck_off  in  10  unsigned calibration trim, back
lft_off  in  10  unsigned calibration trim, left
rght_off  in  10  unsigned calibration trim, right
wrt  in  1  capture strobe for speeds and offsets
arm  in  1  1 = pulses allowed, 0 = outputs held low
frnt  out  1  front ESC PWM
bck  out  1  back ESC PWM
lft  out  1  left ESC PWM
rght  out  1  right ESC PWM
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (asynchronous, rst_n=0):
  - period counter cnt=0;
  - shadow and active widths = MIN_PULSE;
  - armed_q=0;
  - frnt, bck, lft, rght = 0; frame_start = 0.
- Period counter:
  - 17-bit cnt counts 0..PERIOD-1, then wraps to 0;
  - runs continuously, independent of arm and wrt.
- frame_start: registered; asserted for exactly the one cycle following cnt==0, so one pulse per PERIOD cycles.
- Compensation, per channel:
  - comp = spd + off, computed at 12 bits;
  - if comp > 2047, comp = 2047 (saturate, no wrap).
- Width:
  - width = MIN_PULSE + comp*SCALE, unsigned, 17 bits;
  - maximum value is 99128, which is less than PERIOD.
- Shadow register:
  - on a cycle with wrt=1, the computed width for each channel is registered into shadow;
  - when wrt=0, shadow holds.
- Active register:
  - on the cycle cnt==PERIOD-1, active <= shadow for all four channels;
  - armed_q <= arm on that same cycle.
- Simultaneous wrt and transfer: if wrt=1 on the cycle cnt==PERIOD-1, the transfer takes the old shadow. The new value first drives the frame after next.
- PWM output:
  - registered: pwm <= armed_q & arm & (cnt < active);
  - each output lags cnt by one cycle;
  - high time is exactly `active` cycles and starts on the same edge as frame_start.
- Disarm:
  - arm=0 forces all outputs low on the next edge, including mid-pulse;
  - re-asserting arm has no effect until the next boundary latches armed_q=1, so no partial pulses are produced.
- Latency: a wrt strobe affects output at the first frame boundary strictly after the shadow update. Worst case is PERIOD+1 cycles.
- Reset mid-operation: all outputs drop asynchronously; after release, frames restart from cnt=0.
- No combinational path from any input to any output.

Test Plan:
1. Reset release, then wrt with all spd=0, off=0, arm=1 -> first frame after arming has each output high for 50000 cycles, low for 75000; frame_start period = 125000.
2. Channel speeds:
   - frnt_spd=2047, off=0 -> frnt high 99128 cycles;
   - bck_spd=1000, off=24 -> 74576 cycles;
   - lft_spd=2000, off=100 -> saturates to 99128;
   - rght_spd=1, off=0 -> 50024.
3. wrt mid-frame (cnt=30000) changing frnt_spd 0->500 -> current pulse stays 50000; next frame pulse is 62000.
4. wrt asserted exactly at cnt=PERIOD-1 -> following frame uses the old width; the frame after that uses the new width.
5. arm dropped at cnt=20000 while pulses high -> all outputs low next cycle. arm re-raised at cnt=60000 -> outputs stay low until the next frame_start, then a full-width pulse.
6. rst_n asserted at cnt=40000 with outputs high -> outputs 0 immediately. After release, cnt restarts and armed_q=0, so no pulse appears until one boundary with arm=1 has passed.

Source files
------------

// File: rtl/esc_quad_pwm.sv
// Four-channel servo-style PWM generator for quadcopter ESCs.
// Trimmed speeds are double-buffered and only take effect at frame boundaries.
module esc_quad_pwm #(
    parameter int PERIOD    = 125000,
    parameter int MIN_PULSE = 50000,
    parameter int SCALE     = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic [9:0]  frnt_off,
    input  logic [9:0]  bck_off,
    input  logic [9:0]  lft_off,
    input  logic [9:0]  rght_off,
    input  logic        wrt,
    input  logic        arm,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        frame_start
);

    localparam logic [16:0] LAST    = 17'(PERIOD - 1);
    localparam logic [16:0] MIN_W   = 17'(MIN_PULSE);
    localparam logic [16:0] SCALE_W = 17'(SCALE);

    // Trim is added at 12 bits and saturated so a large offset never wraps to a short pulse.
    function automatic logic [16:0] calc_width(input logic [10:0] spd, input logic [9:0] off);
        logic [11:0] sum;
        logic [10:0] comp;
        sum  = {1'b0, spd} + {2'b00, off};
        comp = sum[11] ? 11'h7ff : sum[10:0];
        return MIN_W + 17'(comp) * SCALE_W;
    endfunction

    logic [16:0] cnt;
    logic        armed_q;
    logic [3:0]  pwm_q;
    logic [16:0] width_c [4];
    logic [16:0] shadow  [4];
    logic [16:0] active  [4];

    always_comb begin
        width_c[0] = calc_width(frnt_spd, frnt_off);
        width_c[1] = calc_width(bck_spd,  bck_off);
        width_c[2] = calc_width(lft_spd,  lft_off);
        width_c[3] = calc_width(rght_spd, rght_off);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            armed_q     <= 1'b0;
            pwm_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= MIN_W;
                active[i] <= MIN_W;
            end
        end else begin
            cnt         <= (cnt == LAST) ? '0 : cnt + 17'd1;
            frame_start <= (cnt == '0);
            if (wrt) begin
                for (int i = 0; i < 4; i++) shadow[i] <= width_c[i];
            end
            // Boundary transfer reads the pre-edge shadow, so a coincident wrt lands a frame later.
            if (cnt == LAST) begin
                for (int i = 0; i < 4; i++) active[i] <= shadow[i];
                armed_q <= arm;
            end
            for (int i = 0; i < 4; i++) pwm_q[i] <= armed_q & arm & (cnt < active[i]);
        end
    end

    assign frnt = pwm_q[0];
    assign bck  = pwm_q[1];
    assign lft  = pwm_q[2];
    assign rght = pwm_q[3];

endmodule

// File: tb/tb_esc_quad_pwm.sv
// Bench for esc_quad_pwm with a shortened frame; a monitor measures each frame's
// pulse widths and length and checks them against per-frame expectations.
module tb_esc_quad_pwm;

    localparam int P    = 2600;
    localparam int MINP = 500;
    localparam int SC   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] frnt_spd = '0, bck_spd = '0, lft_spd = '0, rght_spd = '0;
    logic [9:0]  frnt_off = '0, bck_off = '0, lft_off = '0, rght_off = '0;
    logic        wrt = 1'b0;
    logic        arm = 1'b0;
    logic        frnt, bck, lft, rght, frame_start;

    esc_quad_pwm #(.PERIOD(P), .MIN_PULSE(MINP), .SCALE(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .frnt_off(frnt_off), .bck_off(bck_off), .lft_off(lft_off), .rght_off(rght_off),
        .wrt(wrt), .arm(arm),
        .frnt(frnt), .bck(bck), .lft(lft), .rght(rght), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f;
        int b;
        int l;
        int r;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cur = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for the next frame_start (cnt==1 at this negedge) and queue that frame's expected widths.
    task automatic next_frame(input int f, input int b, input int l, input int r);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < P + 10) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_start_wait: none within %0d cycles, expected one per %0d", n, P);
        end
        sb.push_back('{f, b, l, r});
        cur = 1;
    endtask

    task automatic goto_cnt(input int c);
        repeat (c - cur) @(negedge clk);
        cur = c;
    endtask

    task automatic write_all(input int fs, input int fo, input int bs, input int bo,
                             input int ls, input int lo, input int rs, input int ro);
        frnt_spd = 11'(fs); frnt_off = 10'(fo);
        bck_spd  = 11'(bs); bck_off  = 10'(bo);
        lft_spd  = 11'(ls); lft_off  = 10'(lo);
        rght_spd = 11'(rs); rght_off = 10'(ro);
        wrt = 1'b1;
        @(negedge clk);
        cur++;
        wrt = 1'b0;
    endtask

    // Monitor: a frame ends at each frame_start; compare its measured high times and length.
    initial begin
        int   hi[4];
        int   len;
        bit   in_frame;
        exp_t e;
        in_frame = 0;
        len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
            end else if (frame_start) begin
                if (in_frame) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL scoreboard_empty: frame ended with no expectation queued");
                    end else begin
                        e = sb.pop_front();
                        check("frnt_high", hi[0], e.f);
                        check("bck_high",  hi[1], e.b);
                        check("lft_high",  hi[2], e.l);
                        check("rght_high", hi[3], e.r);
                        check("frame_len", len, P);
                    end
                end
                hi[0] = int'(frnt); hi[1] = int'(bck); hi[2] = int'(lft); hi[3] = int'(rght);
                len = 1;
                in_frame = 1;
            end else if (in_frame) begin
                hi[0] += int'(frnt); hi[1] += int'(bck); hi[2] += int'(lft); hi[3] += int'(rght);
                len++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_frnt", int'(frnt), 0);
        check("rst_bck", int'(bck), 0);
        check("rst_lft", int'(lft), 0);
        check("rst_rght", int'(rght), 0);
        check("rst_frame_start", int'(frame_start), 0);
        rst_n = 1'b1;

        // Unarmed first frame; arm and write minimum speeds.
        next_frame(0, 0, 0, 0);
        goto_cnt(10);
        arm = 1'b1;
        write_all(0, 0, 0, 0, 0, 0, 0, 0);

        // Minimum pulse; load per-channel speeds including saturation.
        next_frame(500, 500, 500, 500);
        goto_cnt(100);
        write_all(2047, 0, 1000, 24, 2000, 100, 1, 0);

        // Back to minimum for the next frame.
        next_frame(2547, 1524, 2547, 501);
        goto_cnt(10);
        write_all(0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-frame write must not disturb the running pulse.
        next_frame(500, 500, 500, 500);
        goto_cnt(300);
        write_all(500, 0, 0, 0, 0, 0, 0, 0);

        // Write on the last cycle of the frame: skipped by this boundary.
        next_frame(1000, 500, 500, 500);
        goto_cnt(P - 1);
        write_all(100, 0, 0, 0, 0, 0, 0, 0);

        next_frame(1000, 500, 500, 500);
        next_frame(600, 500, 500, 500);

        // Disarm mid-pulse, re-arm after the pulse would have ended.
        next_frame(200, 200, 200, 200);
        goto_cnt(200);
        arm = 1'b0;
        goto_cnt(1200);
        arm = 1'b1;

        next_frame(600, 500, 500, 500);

        // Reset in the middle of a pulse.
        next_frame(600, 500, 500, 500);
        goto_cnt(300);
        check("pre_reset_frnt", int'(frnt), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_frnt", int'(frnt), 0);
        check("async_rst_bck", int'(bck), 0);
        check("async_rst_lft", int'(lft), 0);
        check("async_rst_rght", int'(rght), 0);
        check("async_rst_frame_start", int'(frame_start), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        next_frame(0, 0, 0, 0);
        next_frame(500, 500, 500, 500);
        next_frame(500, 500, 500, 500);
        repeat (2) @(negedge clk);
        check("scoreboard_residue", sb.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
